// File: rtl/pc_gen.sv
`timescale 1ns/1ps
// Program-counter generator: next-PC selection, misaligned-target trap redirect,
// and a circular return-address stack for call/return prediction.
module pc_gen #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] RS1,
    input  logic [XLEN-1:0] TrapVec,
    input  logic            IsCall,
    input  logic            IsRet,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [XLEN-1:0] RasTop,
    output logic            RasValid,
    output logic            MisalignErr,
    output logic [XLEN-1:0] BadAddr
);

    localparam int unsigned     PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned     CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d, wr_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  target, jalr_sum, pc_d, bad_d;
    logic             misalign, err_d, wr_en, push;

    assign PCPlus4  = PC + XLEN'(4);
    assign RasValid = (cnt_q != '0);
    assign RasTop   = RasValid ? ras_q[top_q] : '0;
    assign jalr_sum = RS1 + ImmExt;

    // Target select and alignment check; only branch/JALR targets can fault.
    always_comb begin
        target = TrapVec;
        unique case (PCSrc)
            2'b00:   target = PCPlus4;
            2'b01:   target = PC + ImmExt;
            2'b10:   target = {jalr_sum[XLEN-1:1], 1'b0};
            default: target = TrapVec;
        endcase
        misalign = ((PCSrc == 2'b01) || (PCSrc == 2'b10)) && (target[1:0] != 2'b00);
    end

    // Next-state for PC, fault capture and the return-address stack.
    always_comb begin
        pc_d   = misalign ? TrapVec : target;
        err_d  = misalign;
        bad_d  = misalign ? target : BadAddr;
        top_d  = top_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = top_q;
        push   = 1'b0;
        if (!Stall && !misalign) begin
            // Call+return on an empty stack degenerates to a plain push.
            push = IsCall && (!IsRet || (cnt_q == '0));
            if (push) begin
                top_d  = top_q + PTR_W'(1);
                wr_idx = top_q + PTR_W'(1);
                wr_en  = 1'b1;
                if (cnt_q != FULL) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (IsCall && IsRet) begin
                wr_en = 1'b1;
            end else if (IsRet && (cnt_q != '0)) begin
                top_d = top_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (PCSrc == 2'b11) begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC          <= RESET_VEC;
            MisalignErr <= 1'b0;
            BadAddr     <= '0;
            top_q       <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            if (!Stall) begin
                PC          <= pc_d;
                MisalignErr <= err_d;
                BadAddr     <= bad_d;
            end
            top_q <= top_d;
            cnt_q <= cnt_d;
            if (wr_en) begin
                ras_q[wr_idx] <= PCPlus4;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
`timescale 1ns/1ps
// Scoreboarded bench for pc_gen: each stimulus step queues its expected outputs,
// which are popped and compared one cycle later.
module tb_pc_gen;

    typedef struct {
        string       nm;
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] tv;
        logic        call;
        logic        ret;
        logic        stall;
        logic [31:0] pc;
        logic [31:0] top;
        logic        valid;
        logic        err;
        logic [31:0] bad;
    } step_t;

    logic        clk, rst, Stall, IsCall, IsRet;
    logic [1:0]  PCSrc;
    logic [31:0] ImmExt, RS1, TrapVec;
    logic [31:0] PC, PCPlus4, RasTop, BadAddr;
    logic        RasValid, MisalignErr;

    int    n_total = 0;
    int    n_bad   = 0;
    step_t sb[$];

    pc_gen #(.XLEN(32), .RESET_VEC(32'h100), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .Stall(Stall), .PCSrc(PCSrc), .ImmExt(ImmExt),
        .RS1(RS1), .TrapVec(TrapVec), .IsCall(IsCall), .IsRet(IsRet),
        .PC(PC), .PCPlus4(PCPlus4), .RasTop(RasTop), .RasValid(RasValid),
        .MisalignErr(MisalignErr), .BadAddr(BadAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic step_t mk(input string nm, input logic [1:0] src,
                                 input logic [31:0] imm, input logic [31:0] rs1,
                                 input logic [31:0] tv, input logic call, input logic ret,
                                 input logic stall, input logic [31:0] pc,
                                 input logic [31:0] top, input logic valid,
                                 input logic err, input logic [31:0] bad);
        step_t s;
        s.nm = nm; s.src = src; s.imm = imm; s.rs1 = rs1; s.tv = tv;
        s.call = call; s.ret = ret; s.stall = stall; s.pc = pc; s.top = top;
        s.valid = valid; s.err = err; s.bad = bad;
        return s;
    endfunction

    // Drive one step (called just after a rising edge), queue its expectation, advance a cycle.
    task automatic apply(input step_t s);
        PCSrc = s.src; ImmExt = s.imm; RS1 = s.rs1; TrapVec = s.tv;
        IsCall = s.call; IsRet = s.ret; Stall = s.stall;
        sb.push_back(s);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t e;
        rst = 1'b0; Stall = 1'b0; PCSrc = 2'b00; ImmExt = '0; RS1 = '0;
        TrapVec = 32'h800; IsCall = 1'b0; IsRet = 1'b0;
        sb.push_back(mk("reset", 2'b00, 0, 0, 32'h800, 0, 0, 0, 32'h100, 0, 0, 0, 0));
        #12;
        e = sb.pop_front();
        n_total++; if (PC !== e.pc) begin n_bad++; $display("FAIL %s pc: got %h want %h", e.nm, PC, e.pc); end
        n_total++; if (RasTop !== e.top) begin n_bad++; $display("FAIL %s rastop: got %h want %h", e.nm, RasTop, e.top); end
        n_total++; if (RasValid !== e.valid) begin n_bad++; $display("FAIL %s rasvalid: got %b want %b", e.nm, RasValid, e.valid); end
        n_total++; if (MisalignErr !== e.err) begin n_bad++; $display("FAIL %s err: got %b want %b", e.nm, MisalignErr, e.err); end
        n_total++; if (BadAddr !== e.bad) begin n_bad++; $display("FAIL %s badaddr: got %h want %h", e.nm, BadAddr, e.bad); end
        n_total++; if (PCPlus4 !== 32'h104) begin n_bad++; $display("FAIL reset pcplus4: got %h want %h", PCPlus4, 32'h104); end
        rst = 1'b1;
    endtask

    task automatic test_seq();
        step_t st[$];
        step_t e;
        st.push_back(mk("seq1", 2'b00, 0, 0, 32'h800, 0, 0, 0, 32'h104, 0, 0, 0, 0));
        st.push_back(mk("seq2", 2'b00, 0, 0, 32'h800, 0, 0, 0, 32'h108, 0, 0, 0, 0));
        st.push_back(mk("seq3", 2'b00, 0, 0, 32'h800, 0, 0, 0, 32'h10C, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            e = sb.pop_front();
            n_total++; if (PC !== e.pc) begin n_bad++; $display("FAIL %s pc: got %h want %h", e.nm, PC, e.pc); end
            n_total++; if (RasValid !== e.valid) begin n_bad++; $display("FAIL %s rasvalid: got %b want %b", e.nm, RasValid, e.valid); end
            n_total++; if (MisalignErr !== e.err) begin n_bad++; $display("FAIL %s err: got %b want %b", e.nm, MisalignErr, e.err); end
        end
        n_total++; if (PCPlus4 !== 32'h110) begin n_bad++; $display("FAIL seq pcplus4: got %h want %h", PCPlus4, 32'h110); end
    endtask

    task automatic test_branch_jalr();
        step_t st[$];
        step_t e;
        st.push_back(mk("to200",    2'b11, 0, 0, 32'h200, 0, 0, 0, 32'h200, 0, 0, 0, 0));
        st.push_back(mk("br_neg",   2'b01, 32'hFFFFFFF0, 0, 32'h800, 0, 0, 0, 32'h1F0, 0, 0, 0, 0));
        st.push_back(mk("to200b",   2'b11, 0, 0, 32'h200, 0, 0, 0, 32'h200, 0, 0, 0, 0));
        st.push_back(mk("br_mis",   2'b01, 32'h6, 0, 32'h800, 0, 0, 0, 32'h800, 0, 0, 1, 32'h206));
        st.push_back(mk("err_drop", 2'b00, 0, 0, 32'h800, 0, 0, 0, 32'h804, 0, 0, 0, 32'h206));
        st.push_back(mk("jalr_ok",  2'b10, 32'h3, 32'h301, 32'h800, 0, 0, 0, 32'h304, 0, 0, 0, 32'h206));
        st.push_back(mk("jalr_mis", 2'b10, 32'h2, 32'h300, 32'h800, 0, 0, 0, 32'h800, 0, 0, 1, 32'h302));
        st.push_back(mk("stall_err",2'b00, 0, 0, 32'h800, 0, 0, 1, 32'h800, 0, 0, 1, 32'h302));
        st.push_back(mk("unstall",  2'b00, 0, 0, 32'h800, 0, 0, 0, 32'h804, 0, 0, 0, 32'h302));
        st.push_back(mk("trap_odd", 2'b11, 0, 0, 32'h202, 0, 0, 0, 32'h202, 0, 0, 0, 32'h302));
        st.push_back(mk("seq_odd",  2'b00, 0, 0, 32'h800, 0, 0, 0, 32'h206, 0, 0, 0, 32'h302));
        foreach (st[i]) begin
            apply(st[i]);
            e = sb.pop_front();
            n_total++; if (PC !== e.pc) begin n_bad++; $display("FAIL %s pc: got %h want %h", e.nm, PC, e.pc); end
            n_total++; if (MisalignErr !== e.err) begin n_bad++; $display("FAIL %s err: got %b want %b", e.nm, MisalignErr, e.err); end
            n_total++; if (BadAddr !== e.bad) begin n_bad++; $display("FAIL %s badaddr: got %h want %h", e.nm, BadAddr, e.bad); end
        end
    endtask

    task automatic test_wrap();
        step_t e;
        apply(mk("to_top", 2'b11, 0, 0, 32'hFFFFFFFC, 0, 0, 0, 32'hFFFFFFFC, 0, 0, 0, 32'h302));
        e = sb.pop_front();
        n_total++; if (PC !== e.pc) begin n_bad++; $display("FAIL %s pc: got %h want %h", e.nm, PC, e.pc); end
        n_total++; if (PCPlus4 !== 32'h0) begin n_bad++; $display("FAIL wrap pcplus4: got %h want %h", PCPlus4, 32'h0); end
        apply(mk("wrap", 2'b00, 0, 0, 32'h800, 0, 0, 0, 32'h0, 0, 0, 0, 32'h302));
        e = sb.pop_front();
        n_total++; if (PC !== e.pc) begin n_bad++; $display("FAIL %s pc: got %h want %h", e.nm, PC, e.pc); end
    endtask

    task automatic test_ras();
        step_t st[$];
        step_t e;
        for (int i = 0; i < 5; i++) begin
            st.push_back(mk("call", 2'b01, 32'h10, 0, 32'h800, 1, 0, 0,
                            32'(i * 16 + 16), 32'(i * 16 + 4), 1, 0, 32'h302));
        end
        st.push_back(mk("ret1", 2'b00, 0, 0, 32'h800, 0, 1, 0, 32'h54, 32'h34, 1, 0, 32'h302));
        st.push_back(mk("ret2", 2'b00, 0, 0, 32'h800, 0, 1, 0, 32'h58, 32'h24, 1, 0, 32'h302));
        st.push_back(mk("ret3", 2'b00, 0, 0, 32'h800, 0, 1, 0, 32'h5C, 32'h14, 1, 0, 32'h302));
        st.push_back(mk("ret4", 2'b00, 0, 0, 32'h800, 0, 1, 0, 32'h60, 32'h0, 0, 0, 32'h302));
        st.push_back(mk("ret5", 2'b00, 0, 0, 32'h800, 0, 1, 0, 32'h64, 32'h0, 0, 0, 32'h302));
        st.push_back(mk("cr_empty", 2'b00, 0, 0, 32'h800, 1, 1, 0, 32'h68, 32'h68, 1, 0, 32'h302));
        st.push_back(mk("call_b",   2'b00, 0, 0, 32'h800, 1, 0, 0, 32'h6C, 32'h6C, 1, 0, 32'h302));
        st.push_back(mk("cr_repl",  2'b00, 0, 0, 32'h800, 1, 1, 0, 32'h70, 32'h70, 1, 0, 32'h302));
        st.push_back(mk("ret_repl", 2'b00, 0, 0, 32'h800, 0, 1, 0, 32'h74, 32'h68, 1, 0, 32'h302));
        st.push_back(mk("trap_clr", 2'b11, 0, 0, 32'h900, 1, 0, 0, 32'h900, 32'h0, 0, 0, 32'h302));
        st.push_back(mk("mis_call", 2'b01, 32'h2, 0, 32'h800, 1, 0, 0, 32'h800, 32'h0, 0, 1, 32'h902));
        apply(mk("to0", 2'b11, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h302));
        e = sb.pop_front();
        n_total++; if (PC !== e.pc) begin n_bad++; $display("FAIL %s pc: got %h want %h", e.nm, PC, e.pc); end
        foreach (st[i]) begin
            apply(st[i]);
            e = sb.pop_front();
            n_total++; if (PC !== e.pc) begin n_bad++; $display("FAIL %s%0d pc: got %h want %h", e.nm, i, PC, e.pc); end
            n_total++; if (RasTop !== e.top) begin n_bad++; $display("FAIL %s%0d rastop: got %h want %h", e.nm, i, RasTop, e.top); end
            n_total++; if (RasValid !== e.valid) begin n_bad++; $display("FAIL %s%0d rasvalid: got %b want %b", e.nm, i, RasValid, e.valid); end
            n_total++; if (MisalignErr !== e.err) begin n_bad++; $display("FAIL %s%0d err: got %b want %b", e.nm, i, MisalignErr, e.err); end
            n_total++; if (BadAddr !== e.bad) begin n_bad++; $display("FAIL %s%0d badaddr: got %h want %h", e.nm, i, BadAddr, e.bad); end
        end
    endtask

    task automatic test_stall();
        step_t st[$];
        step_t e;
        st.push_back(mk("pre_call", 2'b00, 0, 0, 32'h800, 1, 0, 0, 32'h804, 32'h804, 1, 0, 32'h902));
        for (int i = 0; i < 3; i++) begin
            st.push_back(mk("stalled", 2'b01, 32'h20, 0, 32'h800, 1, 0, 1, 32'h804, 32'h804, 1, 0, 32'h902));
        end
        st.push_back(mk("release",  2'b01, 32'h20, 0, 32'h800, 1, 0, 0, 32'h824, 32'h808, 1, 0, 32'h902));
        st.push_back(mk("call3",    2'b00, 0, 0, 32'h800, 1, 0, 0, 32'h828, 32'h828, 1, 0, 32'h902));
        st.push_back(mk("pop1",     2'b00, 0, 0, 32'h800, 0, 1, 0, 32'h82C, 32'h808, 1, 0, 32'h902));
        foreach (st[i]) begin
            apply(st[i]);
            e = sb.pop_front();
            n_total++; if (PC !== e.pc) begin n_bad++; $display("FAIL %s%0d pc: got %h want %h", e.nm, i, PC, e.pc); end
            n_total++; if (RasTop !== e.top) begin n_bad++; $display("FAIL %s%0d rastop: got %h want %h", e.nm, i, RasTop, e.top); end
            n_total++; if (RasValid !== e.valid) begin n_bad++; $display("FAIL %s%0d rasvalid: got %b want %b", e.nm, i, RasValid, e.valid); end
            n_total++; if (MisalignErr !== e.err) begin n_bad++; $display("FAIL %s%0d err: got %b want %b", e.nm, i, MisalignErr, e.err); end
        end
    endtask

    task automatic test_async_reset();
        step_t st[$];
        step_t e;
        // Reset pulse lands mid-cycle; outputs must respond before the next edge.
        #2 rst = 1'b0;
        sb.push_back(mk("async_rst", 2'b00, 0, 0, 32'h800, 0, 0, 0, 32'h100, 32'h0, 0, 0, 32'h0));
        #1;
        e = sb.pop_front();
        n_total++; if (PC !== e.pc) begin n_bad++; $display("FAIL %s pc: got %h want %h", e.nm, PC, e.pc); end
        n_total++; if (RasTop !== e.top) begin n_bad++; $display("FAIL %s rastop: got %h want %h", e.nm, RasTop, e.top); end
        n_total++; if (RasValid !== e.valid) begin n_bad++; $display("FAIL %s rasvalid: got %b want %b", e.nm, RasValid, e.valid); end
        n_total++; if (BadAddr !== e.bad) begin n_bad++; $display("FAIL %s badaddr: got %h want %h", e.nm, BadAddr, e.bad); end
        #2 rst = 1'b1;
        st.push_back(mk("post_seq",  2'b00, 0, 0, 32'h800, 0, 0, 0, 32'h104, 32'h0, 0, 0, 32'h0));
        st.push_back(mk("post_ret",  2'b00, 0, 0, 32'h800, 0, 1, 0, 32'h108, 32'h0, 0, 0, 32'h0));
        st.push_back(mk("post_call", 2'b00, 0, 0, 32'h800, 1, 0, 0, 32'h10C, 32'h10C, 1, 0, 32'h0));
        foreach (st[i]) begin
            apply(st[i]);
            e = sb.pop_front();
            n_total++; if (PC !== e.pc) begin n_bad++; $display("FAIL %s pc: got %h want %h", e.nm, PC, e.pc); end
            n_total++; if (RasTop !== e.top) begin n_bad++; $display("FAIL %s rastop: got %h want %h", e.nm, RasTop, e.top); end
            n_total++; if (RasValid !== e.valid) begin n_bad++; $display("FAIL %s rasvalid: got %b want %b", e.nm, RasValid, e.valid); end
            n_total++; if (BadAddr !== e.bad) begin n_bad++; $display("FAIL %s badaddr: got %h want %h", e.nm, BadAddr, e.bad); end
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch_jalr();
        test_wrap();
        test_ras();
        test_stall();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC and address width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 0, meaning the PC value loaded on reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, meaning the number of return-address-stack entries (power of 2, at least 2).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port Stall, input, 1 bit: when high, hold all state.
REQ-007 SHALL have port PCSrc, input, 2 bits, selecting the next PC: 00 sequential, 01 branch, 10 JALR, 11 trap.
REQ-008 SHALL have port ImmExt, input, XLEN bits: sign-extended immediate.
REQ-009 SHALL have port RS1, input, XLEN bits: JALR base register value.
REQ-010 SHALL have port TrapVec, input, XLEN bits: trap handler address.
REQ-011 SHALL have port IsCall, input, 1 bit: the current instruction is a call (push to the return-address stack).
REQ-012 SHALL have port IsRet, input, 1 bit: the current instruction is a return (pop from the return-address stack).
REQ-013 SHALL have port PC, output, XLEN bits: current program counter, registered.
REQ-014 SHALL have port PCPlus4, output, XLEN bits: PC+4, combinational, wrapping modulo 2^XLEN.
REQ-015 SHALL have port RasTop, output, XLEN bits: predicted return address (top entry); 0 when the stack is empty.
REQ-016 SHALL have port RasValid, output, 1 bit: high when the return-address stack holds at least one entry.
REQ-017 SHALL have port MisalignErr, output, 1 bit: registered one-cycle pulse on a misaligned jump or branch target.
REQ-018 SHALL have port BadAddr, output, XLEN bits: the most recent misaligned target, registered.

Function
REQ-019 SHALL define an accepted cycle as a rising clk edge with Stall=0; only accepted cycles update PC, the stack, MisalignErr and BadAddr.
REQ-020 SHALL compute the target as follows: PCSrc=00 gives PC+4; 01 gives PC+ImmExt; 10 gives (RS1+ImmExt) with bit 0 cleared; 11 gives TrapVec. All sums are XLEN-bit, with carry discarded.
REQ-021 SHALL treat a target as misaligned when PCSrc is 01 or 10 and target[1:0]!=0; misaligned targets apply only to those two selections.
REQ-022 SHALL, on an accepted cycle with a misaligned target: load PC<=TrapVec, BadAddr<=target and MisalignErr<=1, and treat IsCall/IsRet as ignored.
REQ-023 SHALL, on any other accepted cycle: load PC<=target and MisalignErr<=0, and hold BadAddr.
REQ-024 SHALL, while Stall=1: hold PC, BadAddr, MisalignErr and the whole stack; IsCall/IsRet have no effect.
REQ-025 SHALL implement the return-address stack as a circular buffer with a top pointer and an occupancy count from 0 to RAS_DEPTH.
REQ-026 SHALL, on a push (accepted cycle, IsCall=1, IsRet=0): write PCPlus4 above the top and increment the count, saturating at RAS_DEPTH; a push when full overwrites the oldest entry.
REQ-027 SHALL, on a pop (accepted cycle, IsRet=1, IsCall=0): move the top down and decrement the count; a pop when empty leaves the count at 0 and the pointer unchanged.
REQ-028 SHALL, when IsCall=1 and IsRet=1 together: replace the top entry with PCPlus4 and leave the count unchanged; if the stack is empty, this behaves as a push.
REQ-029 SHALL, on an accepted cycle with PCSrc=11 (trap): clear the count to 0 after any push or pop in that cycle.
REQ-030 SHALL derive RasTop and RasValid combinationally from the current state, with zero-cycle latency.

Reset
REQ-031 SHALL, while rst=0 and asynchronously: PC=RESET_VEC; stack count, pointer and all entries =0; MisalignErr=0; BadAddr=0.
REQ-032 SHALL resume accepted-cycle updates at the first rising clk edge after rst rises; a reset asserted mid-operation discards all stack contents.

Verification
REQ-033 SHALL cover: reset with RESET_VEC=0x100, then 3 sequential cycles -> PC = 0x100, 0x104, 0x108, 0x10C.
REQ-034 SHALL cover: PC=0x200, PCSrc=01, ImmExt=0xFFFFFFF0 -> PC=0x1F0; with ImmExt=0x6 -> PC=TrapVec, MisalignErr=1 for one cycle, BadAddr=0x206.
REQ-035 SHALL cover: PCSrc=10, RS1=0x301, ImmExt=0x3 -> PC=0x304 (bit 0 cleared, aligned, no error).
REQ-036 SHALL cover: 5 calls with RAS_DEPTH=4 from PCs 0x0, 0x10, 0x20, 0x30, 0x40 -> RasTop=0x44, count 4; 4 returns -> RasTop sequence 0x44, 0x34, 0x24, 0x14, then RasValid=0; a 5th return -> no change.
REQ-037 SHALL cover: Stall=1 for 3 cycles with PCSrc=01, IsCall=1 -> PC, RasTop and RasValid unchanged; on the Stall=0 cycle exactly one push and one branch occur.
REQ-038 SHALL cover: rst pulsed low between clk edges with 2 entries on the stack -> PC=RESET_VEC and RasValid=0 immediately, before the next edge.
